// File: rtl/sa_ctrl_pkg.sv
// sa_ctrl_pkg
// Definitions shared by the systolic-array sequencer and its operand skew mux.
// It holds the following:
//   - the default array geometry and drain time-out
//   - the controller state encoding
//   - index helpers for the packed matrix and lane vectors
//     (a_mat, b_mat, z_out, sa_a_w, sa_b_n).
package sa_ctrl_pkg;

    localparam int N_DEF       = 3;
    localparam int DW_DEF      = 8;
    localparam int ACCW_DEF    = 16;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // LSB of element [r][c] in a row-major packed N x N matrix of w-bit elements.
    function automatic int elem_lsb(input int r, input int c, input int n, input int w);
        return (r * n + c) * w;
    endfunction

    // LSB of lane i in a packed vector of w-bit lanes.
    function automatic int lane_lsb(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/sa_skew_mux.sv
// sa_skew_mux
// This is combinational wavefront selection for the systolic array.
// For wave index k, the outputs are:
//   - west lane i  = A[i][k-i]
//   - north lane j = B[k-j][j]
// Out-of-range indices are zero-filled and never wrap around.
// Ports:
//   a_mat, b_mat : registered operand matrices, row-major packed
//   k            : wave index
//   a_w, b_n     : west / north operand lanes, lane i at [i*DW +: DW]
module sa_skew_mux
    import sa_ctrl_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int KW = 3
) (
    input  logic [N*N*DW-1:0] a_mat,
    input  logic [N*N*DW-1:0] b_mat,
    input  logic [KW-1:0]     k,
    output logic [N*DW-1:0]   a_w,
    output logic [N*DW-1:0]   b_n
);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            logic [DW-1:0] a_lane;
            logic [DW-1:0] b_lane;
            int            src;

            always_comb begin
                a_lane = '0;
                b_lane = '0;
                // Row/column gi lags the wave by gi steps; src is the element
                // index along the operand's inner dimension.
                src    = int'(k) - gi;
                if (src >= 0 && src < N) begin
                    a_lane = DW'(a_mat >> elem_lsb(gi, src, N, DW));
                    b_lane = DW'(b_mat >> elem_lsb(src, gi, N, DW));
                end
            end

            assign a_w[lane_lsb(gi, DW) +: DW] = a_lane;
            assign b_n[lane_lsb(gi, DW) +: DW] = b_lane;
        end
    endgenerate

endmodule

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl
// This block sequences one N x N output-stationary systolic-array job.
// The sequence is:
//   - accept the operands
//   - clear the array for one cycle
//   - feed the skewed wavefront (2N-1 waves)
//   - wait for sa_done, bounded by TIMEOUT drain cycles
//   - hold the captured result until the consumer accepts it.
// Ports:
//   job_valid/job_ready, a_mat, b_mat : operand job handshake
//   sa_rst_n, sa_en, sa_a_w, sa_b_n  : array control and operands (registered)
//   sa_z, sa_done                    : array result and completion
//   z_out, z_valid/z_ready           : result handshake
//   err_timeout                      : the held result was forced by time-out
module systolic_seq_ctrl
    import sa_ctrl_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DW      = DW_DEF,
    parameter int ACCW    = ACCW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [N*N*DW-1:0]     a_mat,
    input  logic [N*N*DW-1:0]     b_mat,
    output logic                  sa_rst_n,
    output logic                  sa_en,
    output logic [N*DW-1:0]       sa_a_w,
    output logic [N*DW-1:0]       sa_b_n,
    input  logic [N*N*ACCW-1:0]   sa_z,
    input  logic                  sa_done,
    output logic [N*N*ACCW-1:0]   z_out,
    output logic                  z_valid,
    input  logic                  z_ready,
    output logic                  err_timeout
);

    localparam int KW = $clog2(2 * N);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [N*N*DW-1:0]     a_q, a_d, b_q, b_d;
    logic [N*N*ACCW-1:0]   z_q, z_d;
    logic                  z_valid_q, z_valid_d;
    logic                  err_q, err_d;
    logic                  sa_rst_n_q, sa_rst_n_d;
    logic                  sa_en_q, sa_en_d;
    logic [N*DW-1:0]       a_w_q, a_w_d, b_n_q, b_n_d;
    logic [N*DW-1:0]       a_w_mux, b_n_mux;

    // The mux looks at the next wave index, so the registered lanes show wave k
    // in the same cycle in which k_q == k.
    sa_skew_mux #(
        .N  (N),
        .DW (DW),
        .KW (KW)
    ) u_skew (
        .a_mat (a_q),
        .b_mat (b_q),
        .k     (k_d),
        .a_w   (a_w_mux),
        .b_n   (b_n_mux)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (job_valid) begin
                    a_d     = a_mat;
                    b_d     = b_mat;
                    err_d   = 1'b0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                k_d     = '0;
                state_d = ST_FEED;
            end
            ST_FEED: begin
                if (k_q == KW'(2 * N - 2)) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (sa_done) begin
                    z_d     = sa_z;
                    state_d = ST_HOLD;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    // Give up waiting: hand over whatever the array holds.
                    z_d     = sa_z;
                    err_d   = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (z_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered images of the state being entered.
        sa_rst_n_d = (state_d != ST_CLEAR);
        sa_en_d    = (state_d == ST_FEED) || (state_d == ST_DRAIN);
        z_valid_d  = (state_d == ST_HOLD);
        a_w_d      = (state_d == ST_FEED) ? a_w_mux : '0;
        b_n_d      = (state_d == ST_FEED) ? b_n_mux : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            z_q        <= '0;
            z_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            sa_rst_n_q <= 1'b0;
            sa_en_q    <= 1'b0;
            a_w_q      <= '0;
            b_n_q      <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            z_q        <= z_d;
            z_valid_q  <= z_valid_d;
            err_q      <= err_d;
            sa_rst_n_q <= sa_rst_n_d;
            sa_en_q    <= sa_en_d;
            a_w_q      <= a_w_d;
            b_n_q      <= b_n_d;
        end
    end

    assign job_ready   = (state_q == ST_IDLE);
    assign sa_rst_n    = sa_rst_n_q;
    assign sa_en       = sa_en_q;
    assign sa_a_w      = a_w_q;
    assign sa_b_n      = b_n_q;
    assign z_out       = z_q;
    assign z_valid     = z_valid_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl
// This is a directed bench for systolic_seq_ctrl.
// A behavioural 3x3 output-stationary array sits behind the controller:
//   - operands pass east/south one PE per cycle
//   - each PE accumulates the product of its inputs
// The array's done flag rises after 3N-2 enabled cycles, or never in stub_mode 1.
module tb_systolic_seq_ctrl;

    localparam int N       = 3;
    localparam int DW      = 8;
    localparam int ACCW    = 16;
    localparam int TIMEOUT = 16;
    localparam int MW      = N * N * DW;
    localparam int ZW      = N * N * ACCW;
    localparam int LW      = N * DW;
    localparam int TW      = 160;

    logic            clk = 1'b0;
    logic            rst;
    logic            job_valid;
    logic            job_ready;
    logic [MW-1:0]   a_mat, b_mat;
    logic            sa_rst_n, sa_en;
    logic [LW-1:0]   sa_a_w, sa_b_n;
    logic [ZW-1:0]   sa_z;
    logic            sa_done;
    logic [ZW-1:0]   z_out;
    logic            z_valid;
    logic            z_ready;
    logic            err_timeout;

    always #5 clk = ~clk;

    systolic_seq_ctrl #(
        .N       (N),
        .DW      (DW),
        .ACCW    (ACCW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .a_mat       (a_mat),
        .b_mat       (b_mat),
        .sa_rst_n    (sa_rst_n),
        .sa_en       (sa_en),
        .sa_a_w      (sa_a_w),
        .sa_b_n      (sa_b_n),
        .sa_z        (sa_z),
        .sa_done     (sa_done),
        .z_out       (z_out),
        .z_valid     (z_valid),
        .z_ready     (z_ready),
        .err_timeout (err_timeout)
    );

    // ---------------- behavioural array ----------------
    logic [ACCW-1:0] acc [N][N];
    logic [DW-1:0]   ar  [N][N];
    logic [DW-1:0]   br  [N][N];
    int              en_cnt;
    int              stub_mode;

    always @(posedge clk or negedge sa_rst_n) begin
        if (!sa_rst_n) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= '0;
                    ar[i][j]  <= '0;
                    br[i][j]  <= '0;
                end
            end
            en_cnt <= 0;
        end else if (sa_en) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    logic [DW-1:0] ai, bi;
                    ai = (j == 0) ? DW'(sa_a_w >> (i * DW)) : ar[i][(j == 0) ? 0 : j - 1];
                    bi = (i == 0) ? DW'(sa_b_n >> (j * DW)) : br[(i == 0) ? 0 : i - 1][j];
                    ar[i][j]  <= ai;
                    br[i][j]  <= bi;
                    acc[i][j] <= acc[i][j] + ACCW'(ai) * ACCW'(bi);
                end
            end
            en_cnt <= en_cnt + 1;
        end
    end

    always_comb begin
        sa_z = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                sa_z = sa_z | (ZW'(acc[i][j]) << ((i * N + j) * ACCW));
            end
        end
    end

    assign sa_done = (stub_mode == 0) && (en_cnt >= 3 * N - 2);

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [MW-1:0] pack_m(input int m[9]);
        logic [MW-1:0] p = '0;
        for (int e = 0; e < 9; e++) p = p | (MW'(DW'(m[e])) << (e * DW));
        return p;
    endfunction

    function automatic logic [ZW-1:0] pack_z(input int m[9]);
        logic [ZW-1:0] p = '0;
        for (int e = 0; e < 9; e++) p = p | (ZW'(ACCW'(m[e])) << (e * ACCW));
        return p;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the CLEAR cycle.
    task automatic start_job(input logic [MW-1:0] a, input logic [MW-1:0] b);
        check("job_ready_before_accept", TW'(job_ready), TW'(1));
        a_mat     = a;
        b_mat     = b;
        job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_zvalid(input string tag);
        int n = 0;
        while (!z_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, TW'(z_valid), TW'(1));
    endtask

    int             sym[9], idm[9], seq[9], rev[9], zm[9];
    int             wv[5][3];
    logic [LW-1:0]  exp_lane;

    initial begin
        sym = '{3, 2, 1, 2, 1, 3, 1, 3, 2};
        idm = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        rev = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        // wv[k] = {row0, row1, row2} lane values for wave k
        wv  = '{'{3, 0, 0}, '{2, 2, 0}, '{1, 1, 1}, '{0, 3, 3}, '{0, 0, 2}};

        rst       = 1'b1;
        job_valid = 1'b0;
        z_ready   = 1'b0;
        a_mat     = '0;
        b_mat     = '0;
        stub_mode = 0;

        // ---- reset values ----
        @(negedge clk);
        check("rst_sa_rst_n", TW'(sa_rst_n), TW'(0));
        check("rst_sa_en", TW'(sa_en), TW'(0));
        check("rst_lanes", TW'({sa_a_w, sa_b_n}), TW'(0));
        check("rst_outputs", TW'({z_valid, err_timeout, z_out}), TW'(0));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_sa_rst_n", TW'(sa_rst_n), TW'(1));
        check("post_rst_job_ready", TW'(job_ready), TW'(1));

        // ---- wavefront ----
        start_job(pack_m(sym), pack_m(sym));
        check("clear_rst_en_ready", TW'({sa_rst_n, sa_en, job_ready}), TW'(0));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp_lane = '0;
            for (int i = 0; i < N; i++) exp_lane = exp_lane | (LW'(DW'(wv[k][i])) << (i * DW));
            check($sformatf("wave%0d_a_w", k), TW'(sa_a_w), TW'(exp_lane));
            check($sformatf("wave%0d_b_n", k), TW'(sa_b_n), TW'(exp_lane));
            check($sformatf("wave%0d_en", k), TW'({sa_en, sa_rst_n}), TW'(2'b11));
        end
        @(negedge clk);
        check("drain_first_lanes_en", TW'({sa_en, sa_a_w, sa_b_n}), TW'({1'b1, 48'h0}));
        wait_zvalid("wave_job_zvalid");
        zm = '{14, 11, 11, 11, 14, 11, 11, 11, 14};
        check("wave_job_z", TW'(z_out), TW'(pack_z(zm)));
        check("wave_job_err_ready", TW'({err_timeout, job_ready}), TW'(0));
        z_ready = 1'b1;
        @(negedge clk);
        z_ready = 1'b0;
        check("wave_job_release", TW'({job_ready, z_valid}), TW'(2'b10));
        $display("job wavefront: z_out=%0h err=%0b", z_out, err_timeout);

        // ---- identity x 1..9 with back-pressure ----
        start_job(pack_m(idm), pack_m(seq));
        wait_zvalid("bp_job_zvalid");
        for (int c = 0; c < 20; c++) begin
            check($sformatf("bp_hold%0d", c), TW'({z_valid, job_ready, err_timeout, z_out}),
                  TW'({1'b1, 1'b0, 1'b0, pack_z(seq)}));
            job_valid = (c == 5 || c == 12);
            if (job_valid) a_mat = '1;
            @(negedge clk);
        end
        job_valid = 1'b0;
        z_ready   = 1'b1;
        @(negedge clk);
        z_ready = 1'b0;
        check("bp_release", TW'({job_ready, z_valid}), TW'(2'b10));
        $display("job backpressure: z_out=%0h err=%0b", z_out, err_timeout);

        // ---- time-out ----
        stub_mode = 1;
        start_job(pack_m(idm), pack_m(idm));
        repeat (22) @(negedge clk);
        check("to_zvalid_low_at_16", TW'(z_valid), TW'(0));
        @(negedge clk);
        check("to_zvalid_at_17", TW'(z_valid), TW'(1));
        check("to_err_set", TW'(err_timeout), TW'(1));
        z_ready = 1'b1;
        @(negedge clk);
        z_ready = 1'b0;
        check("to_err_kept_idle", TW'({err_timeout, job_ready}), TW'(2'b11));
        $display("job timeout: err=%0b", err_timeout);
        stub_mode = 0;
        start_job(pack_m(idm), pack_m(seq));
        check("to_err_cleared", TW'(err_timeout), TW'(0));
        wait_zvalid("post_to_zvalid");
        check("post_to_z", TW'(z_out), TW'(pack_z(seq)));
        z_ready = 1'b1;
        @(negedge clk);
        z_ready = 1'b0;
        $display("job after timeout: z_out=%0h err=%0b", z_out, err_timeout);

        // ---- reset in the middle of FEED ----
        start_job(pack_m(sym), pack_m(sym));
        repeat (3) @(negedge clk);
        check("mid_feed_en", TW'(sa_en), TW'(1));
        #2 rst = 1'b1;
        #1;
        check("async_rst_outputs", TW'({sa_en, sa_rst_n, z_valid, sa_a_w}), TW'(0));
        check("async_rst_job_ready", TW'(job_ready), TW'(1));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_job(pack_m(idm), pack_m(rev));
        wait_zvalid("post_rst_zvalid");
        check("post_rst_z", TW'(z_out), TW'(pack_z(rev)));
        z_ready = 1'b1;
        @(negedge clk);
        z_ready = 1'b0;
        $display("job after reset: z_out=%0h err=%0b", z_out, err_timeout);

        // ---- back-to-back ----
        z_ready = 1'b1;
        check("b2b_ready", TW'(job_ready), TW'(1));
        a_mat     = pack_m(seq);
        b_mat     = pack_m(idm);
        job_valid = 1'b1;
        @(negedge clk);
        wait_zvalid("b2b_first_zvalid");
        check("b2b_first_z", TW'(z_out), TW'(pack_z(seq)));
        a_mat = pack_m(idm);
        b_mat = pack_m(sym);
        @(negedge clk);
        check("b2b_gap_idle", TW'({z_valid, job_ready}), TW'(2'b01));
        @(negedge clk);
        check("b2b_second_accept", TW'({job_ready, sa_rst_n}), TW'(0));
        $display("job b2b first: z_out=%0h", pack_z(seq));
        wait_zvalid("b2b_second_zvalid");
        check("b2b_second_z", TW'(z_out), TW'(pack_z(sym)));
        job_valid = 1'b0;
        @(negedge clk);
        check("b2b_pulse_one_cycle", TW'({z_valid, job_ready}), TW'(2'b01));
        z_ready = 1'b0;
        $display("job b2b second: z_out=%0h", pack_z(sym));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

endmodule
